// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter that shares one APB master bridge between NREQ requesters.
// Latches the winning command, watches the bus for completion/error/timeout and returns ack/err/rdata.
module apb_master_arbiter #(
    parameter int NREQ      = 4,
    parameter int DATAWIDTH = 8,
    parameter int ADDRWIDTH = 8,
    parameter int TIMEOUT   = 16
) (
    input  logic                            PCLK,
    input  logic                            PRESET,
    input  logic [NREQ-1:0]                 req,
    input  logic [NREQ-1:0]                 req_rw,
    input  logic [NREQ*(ADDRWIDTH+1)-1:0]   req_addr,
    input  logic [NREQ*DATAWIDTH-1:0]       req_wdata,
    input  logic                            PENABLE,
    input  logic                            PREADY,
    input  logic                            PSLVERR,
    input  logic [DATAWIDTH-1:0]            apb_read_data_out,
    output logic                            transfer,
    output logic                            READ_WRITE,
    output logic [ADDRWIDTH:0]              apb_write_paddr,
    output logic [ADDRWIDTH:0]              apb_read_paddr,
    output logic [DATAWIDTH-1:0]            apb_write_data,
    output logic [NREQ-1:0]                 grant,
    output logic [NREQ-1:0]                 ack,
    output logic [NREQ-1:0]                 err,
    output logic [DATAWIDTH-1:0]            rdata
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t                 r_state;
    logic [IW-1:0]          r_last;
    logic [CW-1:0]          r_cnt;
    logic                   r_transfer;
    logic                   r_rw;
    logic [ADDRWIDTH:0]     r_write_paddr;
    logic [ADDRWIDTH:0]     r_read_paddr;
    logic [DATAWIDTH-1:0]   r_write_data;
    logic [NREQ-1:0]        r_grant;
    logic [NREQ-1:0]        r_ack;
    logic [NREQ-1:0]        r_err;
    logic [DATAWIDTH-1:0]   r_rdata;

    logic [ADDRWIDTH:0]     w_addr  [NREQ];
    logic [DATAWIDTH-1:0]   w_wdata [NREQ];
    logic [IW-1:0]          w_cand  [NREQ];
    logic                   w_any;
    logic [IW-1:0]          w_win;
    logic                   w_ok;
    logic                   w_tmo;
    logic                   w_finish;

    // w_cand[k] is the requester index checked k-th, starting just after the last winner
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
        logic [IW:0] w_sum;
        assign w_addr[gi]  = req_addr[gi*(ADDRWIDTH+1) +: (ADDRWIDTH+1)];
        assign w_wdata[gi] = req_wdata[gi*DATAWIDTH +: DATAWIDTH];
        assign w_sum       = {1'b0, r_last} + (IW+1)'(gi + 1);
        assign w_cand[gi]  = (w_sum >= (IW+1)'(NREQ)) ? IW'(w_sum - (IW+1)'(NREQ)) : IW'(w_sum);
    end

    always_comb begin
        w_any = |req;
        w_win = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[w_cand[k]]) begin
                w_win = w_cand[k];
            end
        end
    end

    assign w_ok     = !PSLVERR && PENABLE && PREADY;
    assign w_tmo    = (r_cnt == CW'(TIMEOUT - 1));
    assign w_finish = PSLVERR || w_ok || w_tmo;

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            r_state       <= S_IDLE;
            r_last        <= IW'(NREQ - 1);
            r_cnt         <= '0;
            r_transfer    <= 1'b0;
            r_rw          <= 1'b0;
            r_write_paddr <= '0;
            r_read_paddr  <= '0;
            r_write_data  <= '0;
            r_grant       <= '0;
            r_ack         <= '0;
            r_err         <= '0;
            r_rdata       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_grant       <= NREQ'(1) << w_win;
                        r_last        <= w_win;
                        r_cnt         <= '0;
                        r_transfer    <= 1'b1;
                        r_rw          <= req_rw[w_win];
                        r_write_paddr <= w_addr[w_win];
                        r_read_paddr  <= w_addr[w_win];
                        r_write_data  <= w_wdata[w_win];
                        r_state       <= S_BUSY;
                    end else begin
                        r_transfer <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (w_finish) begin
                        // Slave error and timeout both report as a failed transfer
                        r_ack      <= r_grant;
                        r_err      <= w_ok ? '0 : r_grant;
                        r_transfer <= 1'b0;
                        if (w_ok && r_rw) begin
                            r_rdata <= apb_read_data_out;
                        end
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_ack   <= '0;
                    r_err   <= '0;
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign transfer        = r_transfer;
    assign READ_WRITE      = r_rw;
    assign apb_write_paddr = r_write_paddr;
    assign apb_read_paddr  = r_read_paddr;
    assign apb_write_data  = r_write_data;
    assign grant           = r_grant;
    assign ack             = r_ack;
    assign err             = r_err;
    assign rdata           = r_rdata;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus randomized traffic,
// compared every cycle against a transaction-level model of the arbiter.
module tb_apb_master_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int TO   = 16;

    logic                   PCLK = 1'b0;
    logic                   PRESET = 1'b0;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ-1:0]        req_rw = '0;
    logic [NREQ*(AW+1)-1:0] req_addr = '0;
    logic [NREQ*DW-1:0]     req_wdata = '0;
    logic                   PENABLE = 1'b0;
    logic                   PREADY = 1'b0;
    logic                   PSLVERR = 1'b0;
    logic [DW-1:0]          apb_read_data_out = '0;
    logic                   transfer;
    logic                   READ_WRITE;
    logic [AW:0]            apb_write_paddr;
    logic [AW:0]            apb_read_paddr;
    logic [DW-1:0]          apb_write_data;
    logic [NREQ-1:0]        grant;
    logic [NREQ-1:0]        ack;
    logic [NREQ-1:0]        err;
    logic [DW-1:0]          rdata;

    apb_master_arbiter #(
        .NREQ(NREQ), .DATAWIDTH(DW), .ADDRWIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET), .req(req), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata), .PENABLE(PENABLE),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .apb_read_data_out(apb_read_data_out),
        .transfer(transfer), .READ_WRITE(READ_WRITE), .apb_write_paddr(apb_write_paddr),
        .apb_read_paddr(apb_read_paddr), .apb_write_data(apb_write_data),
        .grant(grant), .ack(ack), .err(err), .rdata(rdata)
    );

    always #5 PCLK = ~PCLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scenario configuration, written by the main sequence only
    logic              rnd_mode = 1'b0;
    logic [NREQ-1:0]   cfg_want = '0;
    logic [NREQ-1:0]   cfg_rw = '0;
    logic [AW:0]       cfg_addr  [NREQ] = '{default: '0};
    logic [DW-1:0]     cfg_wdata [NREQ] = '{default: '0};
    int                cfg_waits = 0;
    logic              cfg_stuck = 1'b0;
    logic              cfg_slverr = 1'b0;
    logic [DW-1:0]     cfg_prdata = '0;

    // Reference model: expected registered outputs after each edge
    logic [NREQ-1:0]   e_grant = '0, e_ack = '0, e_err = '0;
    logic              e_transfer = 1'b0, e_rw = 1'b0;
    logic [AW:0]       e_addr = '0;
    logic [DW-1:0]     e_wdata = '0, e_rdata = '0;
    int                m_owner = -1, m_age = 0, m_last = NREQ - 1;
    bit                m_done = 1'b0;

    initial forever begin
        int w;
        bit fin, bad;
        @(posedge PCLK or posedge PRESET);
        if (PRESET) begin
            e_grant = '0; e_ack = '0; e_err = '0; e_transfer = 1'b0; e_rw = 1'b0;
            e_addr = '0; e_wdata = '0; e_rdata = '0;
            m_owner = -1; m_age = 0; m_last = NREQ - 1; m_done = 1'b0;
        end else if (m_done) begin
            e_ack = '0; e_err = '0; e_grant = '0; m_done = 1'b0; m_owner = -1;
        end else if (m_owner >= 0) begin
            fin = 1'b0; bad = 1'b0;
            if (PSLVERR) begin fin = 1'b1; bad = 1'b1; end
            else if (PENABLE && PREADY) fin = 1'b1;
            else if (m_age == TO - 1) begin fin = 1'b1; bad = 1'b1; end
            m_age++;
            if (fin) begin
                e_ack[m_owner] = 1'b1;
                e_err[m_owner] = bad;
                e_transfer = 1'b0;
                if (!bad && e_rw) e_rdata = apb_read_data_out;
                m_done = 1'b1;
            end
        end else if (req != 0) begin
            w = -1;
            for (int k = 1; k <= NREQ; k++) begin
                if (w < 0 && req[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
            end
            m_owner = w; m_last = w; m_age = 0;
            e_grant = '0; e_grant[w] = 1'b1;
            e_transfer = 1'b1;
            e_rw = req_rw[w];
            e_addr = req_addr[w*(AW+1) +: (AW+1)];
            e_wdata = req_wdata[w*DW +: DW];
        end
    end

    // Per-cycle compare, fairness tracking, then requester and bus drive
    int          wait_cnt [NREQ] = '{default: 0};
    logic [NREQ-1:0] prev_grant = '0;
    int          bus_cycle = 0, b_waits = 0;
    logic        b_stuck = 1'b0, b_slverr = 1'b0;

    initial forever begin
        @(negedge PCLK);
        check("grant", grant, e_grant);
        check("ack", ack, e_ack);
        check("err", err, e_err);
        check("transfer", transfer, e_transfer);
        check("READ_WRITE", READ_WRITE, e_rw);
        check("apb_write_paddr", apb_write_paddr, e_addr);
        check("apb_read_paddr", apb_read_paddr, e_addr);
        check("apb_write_data", apb_write_data, e_wdata);
        check("rdata", rdata, e_rdata);
        check("grant_onehot", ($countones(grant) <= 1), 1'b1);
        for (int i = 0; i < NREQ; i++) begin
            if (!req[i]) wait_cnt[i] = 0;
            else if (grant != 0 && prev_grant == 0) begin
                if (grant[i]) wait_cnt[i] = 0;
                else begin
                    wait_cnt[i]++;
                    check("starvation_bound", (wait_cnt[i] <= NREQ - 1), 1'b1);
                end
            end
        end
        prev_grant = grant;

        for (int i = 0; i < NREQ; i++) begin
            if (PRESET) req[i] = 1'b0;
            else if (req[i] && ack[i]) req[i] = 1'b0;
            else if (!req[i] && cfg_want[i] && (!rnd_mode || $urandom_range(0, 3) == 0)) begin
                req[i] = 1'b1;
                req_rw[i] = rnd_mode ? 1'($urandom_range(0, 1)) : cfg_rw[i];
                req_addr[i*(AW+1) +: (AW+1)] = rnd_mode ? (AW+1)'($urandom) : cfg_addr[i];
                req_wdata[i*DW +: DW] = rnd_mode ? DW'($urandom) : cfg_wdata[i];
            end
        end

        if (transfer) begin
            bus_cycle++;
            if (bus_cycle == 1) begin
                b_waits  = rnd_mode ? int'($urandom_range(0, 3)) : cfg_waits;
                b_stuck  = rnd_mode ? ($urandom_range(0, 15) == 0) : cfg_stuck;
                b_slverr = rnd_mode ? ($urandom_range(0, 7) == 0) : cfg_slverr;
            end
            PENABLE = (bus_cycle >= 2);
            PREADY  = PENABLE && !b_stuck && (bus_cycle - 2 >= b_waits);
            PSLVERR = PENABLE && b_slverr && (bus_cycle - 2 >= b_waits);
        end else begin
            bus_cycle = 0; PENABLE = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
        end
        apb_read_data_out = rnd_mode ? DW'($urandom) : cfg_prdata;
    end

    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        do begin tick(); n++; end while (ack == 0 && n < 64);
        check("ack_seen", (ack != 0), 1'b1);
    endtask

    task automatic wait_grant(output logic [NREQ-1:0] g);
        int n = 0;
        while (grant == 0 && n < 64) begin tick(); n++; end
        check("grant_seen", (grant != 0), 1'b1);
        g = grant;
        while (grant != 0 && n < 128) begin tick(); n++; end
    endtask

    task automatic drain();
        int n = 0;
        while ((req != 0 || grant != 0) && n < 200) begin tick(); n++; end
        check("drained", (req == 0 && grant == 0), 1'b1);
    endtask

    logic [NREQ-1:0] rr_exp [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    initial begin
        int n;
        logic [NREQ-1:0] g;
        #1 PRESET = 1'b1;
        tick(); tick();
        check("rst_grant", grant, 0);
        check("rst_transfer", transfer, 0);
        check("rst_ack", ack, 0);
        check("rst_rdata", rdata, 0);
        PRESET = 1'b0;
        tick();

        // Single write
        cfg_rw = '0; cfg_addr[0] = 9'h012; cfg_wdata[0] = 8'hA5; cfg_want = 4'b0001;
        tick(); cfg_want = '0;
        check("wr_transfer", transfer, 1);
        check("wr_grant", grant, 4'b0001);
        check("wr_paddr", apb_write_paddr, 9'h012);
        check("wr_wdata", apb_write_data, 8'hA5);
        wait_ack(n);
        check("wr_latency", n, 2);
        check("wr_ack", ack, 4'b0001);
        check("wr_err", err, 4'b0000);
        tick();
        check("wr_ack_cleared", ack, 0);
        check("wr_grant_cleared", grant, 0);

        // Read from slave 2 with one wait state
        cfg_rw = 4'b0010; cfg_addr[1] = 9'h105; cfg_waits = 1; cfg_prdata = 8'h3C; cfg_want = 4'b0010;
        tick(); cfg_want = '0;
        check("rd_rw", READ_WRITE, 1);
        check("rd_paddr", apb_read_paddr, 9'h105);
        wait_ack(n);
        check("rd_latency", n, 3);
        check("rd_ack", ack, 4'b0010);
        check("rd_rdata", rdata, 8'h3C);
        tick();
        cfg_waits = 0; cfg_rw = '0;

        // Round robin from reset with all requesters held
        PRESET = 1'b1; tick(); PRESET = 1'b0;
        cfg_want = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_grant(g);
            check("rr_order", g, rr_exp[k]);
        end
        cfg_want = '0;
        drain();

        // Slave error on requester 2
        cfg_addr[2] = 9'h0AA; cfg_wdata[2] = 8'h5A; cfg_slverr = 1'b1; cfg_want = 4'b0100;
        tick(); cfg_want = '0;
        wait_ack(n);
        check("slverr_ack", ack, 4'b0100);
        check("slverr_err", err, 4'b0100);
        check("slverr_transfer", transfer, 0);
        tick();
        check("slverr_idle_grant", grant, 0);
        cfg_slverr = 1'b0;

        // Timeout on requester 0, then a normal transfer
        cfg_stuck = 1'b1; cfg_want = 4'b0001;
        tick(); cfg_want = '0;
        wait_ack(n);
        check("tmo_latency", n, TO);
        check("tmo_err", err, 4'b0001);
        check("tmo_transfer", transfer, 0);
        tick();
        cfg_stuck = 1'b0; cfg_want = 4'b0010;
        tick(); cfg_want = '0;
        wait_ack(n);
        check("after_tmo_ack", ack, 4'b0010);
        check("after_tmo_err", err, 0);
        tick();

        // Reset while busy
        cfg_stuck = 1'b1; cfg_want = 4'b0001;
        tick(); cfg_want = '0;
        tick(); tick();
        #2 PRESET = 1'b1;
        #1;
        check("arst_grant", grant, 0);
        check("arst_transfer", transfer, 0);
        check("arst_ack", ack, 0);
        tick(); tick();
        PRESET = 1'b0; cfg_stuck = 1'b0; cfg_want = 4'b1000;
        tick(); cfg_want = '0;
        check("post_rst_grant", grant, 4'b1000);
        wait_ack(n);
        check("post_rst_ack", ack, 4'b1000);
        tick();

        // Randomized traffic
        rnd_mode = 1'b1; cfg_want = 4'b1111;
        repeat (3000) tick();
        cfg_want = '0;
        drain();
        rnd_mode = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
